// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU definitions: ALUC_* constants, opcode encodings, instruction
// field positions and the command sequencer FSM encoding.
package alu_cmd_sequencer_pkg;

   localparam int ALUC_OP_W    = 4;
   localparam int ALUC_INSTR_W = 32;
   localparam int ALUC_RF_AW   = 3;
   localparam int ALUC_IMM_W   = 16;

   // Instruction word field positions
   localparam int ALUC_OP_HI  = 31;
   localparam int ALUC_OP_LO  = 28;
   localparam int ALUC_RD_HI  = 27;
   localparam int ALUC_RD_LO  = 25;
   localparam int ALUC_RS_HI  = 24;
   localparam int ALUC_RS_LO  = 22;
   localparam int ALUC_RT_HI  = 21;
   localparam int ALUC_RT_LO  = 19;
   localparam int ALUC_IMM_SEL = 18;
   localparam int ALUC_IMM_HI = 15;
   localparam int ALUC_IMM_LO = 0;

   typedef enum logic [ALUC_OP_W-1:0] {
      ALUC_ADD = 4'h0,
      ALUC_SUB = 4'h1,
      ALUC_AND = 4'h2,
      ALUC_OR  = 4'h3,
      ALUC_XOR = 4'h4,
      ALUC_LUI = 4'h5,
      ALUC_SLL = 4'h6,
      ALUC_SRL = 4'h7,
      ALUC_SRA = 4'h8
   } aluc_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CAPT  = 2'd2,
      ST_WB    = 2'd3
   } seq_state_e;

   function automatic logic aluc_op_legal(input logic [ALUC_OP_W-1:0] op);
      return op <= ALUC_SRA;
   endfunction

   // Only arithmetic ops report overflow to the host
   function automatic logic aluc_op_has_of(input logic [ALUC_OP_W-1:0] op);
      return (op == ALUC_ADD) || (op == ALUC_SUB);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one sync write port, R0 hardwired to 0.
module alu_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int RF_DEPTH   = 8,
   parameter int ADDR_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     ra_addr,
   output logic [DATA_WIDTH-1:0] ra_data,
   input  logic [ADDR_W-1:0]     rb_addr,
   output logic [DATA_WIDTH-1:0] rb_data,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata
);

   logic [DATA_WIDTH-1:0] mem [RF_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
   assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences one instruction at a time through an external combinational ALU:
// IDLE -> ISSUE -> CAPT -> WB, with a small register file for operands/results.
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RF_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   input  logic [31:0]           instr,
   output logic                  instr_ready,
   input  logic                  cfg_we,
   input  logic [2:0]            cfg_addr,
   input  logic [DATA_WIDTH-1:0] cfg_wdata,
   output logic [3:0]            alu_opcode,
   output logic [DATA_WIDTH-1:0] alu_dina,
   output logic [DATA_WIDTH-1:0] alu_dinb,
   input  logic [DATA_WIDTH-1:0] alu_doutr,
   input  logic                  alu_doutz,
   input  logic                  alu_of,
   output logic                  res_valid,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_zero,
   output logic                  res_of,
   output logic                  res_err,
   output logic [2:0]            res_rd,
   output logic                  of_sticky
);

   seq_state_e state_q, state_d;

   logic [ALUC_OP_W-1:0]  in_op;
   logic [ALUC_RF_AW-1:0] in_rd, in_rs, in_rt;
   logic                  in_imm_sel;
   logic [ALUC_IMM_W-1:0] in_imm;
   logic                  unused_instr_bits;

   assign in_op      = instr[ALUC_OP_HI:ALUC_OP_LO];
   assign in_rd      = instr[ALUC_RD_HI:ALUC_RD_LO];
   assign in_rs      = instr[ALUC_RS_HI:ALUC_RS_LO];
   assign in_rt      = instr[ALUC_RT_HI:ALUC_RT_LO];
   assign in_imm_sel = instr[ALUC_IMM_SEL];
   assign in_imm     = instr[ALUC_IMM_HI:ALUC_IMM_LO];
   assign unused_instr_bits = ^instr[17:16];

   logic [DATA_WIDTH-1:0] rs_data, rt_data, opb;
   logic                  accept;

   logic [ALUC_RF_AW-1:0] rd_q;
   logic                  illegal_q, has_of_q;
   logic [DATA_WIDTH-1:0] cap_r_q;
   logic                  cap_z_q, cap_of_q;

   logic                  rf_we, wb_we;
   logic [ALUC_RF_AW-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;

   assign instr_ready = (state_q == ST_IDLE) && !cfg_we && !rst;
   assign accept      = instr_valid && instr_ready;
   assign opb         = in_imm_sel ? {{(DATA_WIDTH-ALUC_IMM_W){1'b0}}, in_imm} : rt_data;

   // WB owns the single write port; host preloads are dropped in that cycle
   assign wb_we    = (state_q == ST_WB) && !illegal_q && !rst;
   assign rf_we    = wb_we || (cfg_we && (state_q != ST_WB));
   assign rf_waddr = wb_we ? rd_q : cfg_addr;
   assign rf_wdata = wb_we ? cap_r_q : cfg_wdata;

   alu_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .RF_DEPTH   (RF_DEPTH),
      .ADDR_W     (ALUC_RF_AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (in_rs),
      .ra_data (rs_data),
      .rb_addr (in_rt),
      .rb_data (rt_data),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_CAPT;
         ST_CAPT:  state_d = ST_WB;
         ST_WB:    state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ALU drive registers load only on accept, so they hold through CAPT and beyond
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q       <= '0;
         illegal_q  <= 1'b0;
         has_of_q   <= 1'b0;
         alu_opcode <= '0;
         alu_dina   <= '0;
         alu_dinb   <= '0;
         cap_r_q    <= '0;
         cap_z_q    <= 1'b0;
         cap_of_q   <= 1'b0;
         of_sticky  <= 1'b0;
      end else begin
         if (accept) begin
            rd_q      <= in_rd;
            illegal_q <= !aluc_op_legal(in_op);
            has_of_q  <= aluc_op_has_of(in_op);
            if (aluc_op_legal(in_op)) begin
               alu_opcode <= in_op;
               alu_dina   <= rs_data;
               alu_dinb   <= opb;
            end else begin
               alu_opcode <= ALUC_ADD;
               alu_dina   <= '0;
               alu_dinb   <= '0;
            end
         end
         if (state_q == ST_CAPT) begin
            cap_r_q  <= alu_doutr;
            cap_z_q  <= alu_doutz;
            cap_of_q <= alu_of;
         end
         if (res_valid && res_of) of_sticky <= 1'b1;
      end
   end

   assign res_valid = (state_q == ST_WB) && !rst;
   assign res_data  = (rst || illegal_q) ? '0 : cap_r_q;
   assign res_zero  = !rst && cap_z_q;
   assign res_of    = !rst && has_of_q && cap_of_q;
   assign res_err   = !rst && illegal_q;
   assign res_rd    = rst ? '0 : rd_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU.
module tb_alu_cmd_sequencer;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic [31:0]   instr;
   logic          instr_ready;
   logic          cfg_we;
   logic [2:0]    cfg_addr;
   logic [DW-1:0] cfg_wdata;
   logic [3:0]    alu_opcode;
   logic [DW-1:0] alu_dina, alu_dinb, alu_doutr;
   logic          alu_doutz, alu_of;
   logic          res_valid, res_zero, res_of, res_err, of_sticky;
   logic [DW-1:0] res_data;
   logic [2:0]    res_rd;

   logic          force_of;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DATA_WIDTH(DW), .RF_DEPTH(8)) dut (
      .clk (clk), .rst (rst),
      .instr_valid (instr_valid), .instr (instr), .instr_ready (instr_ready),
      .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
      .alu_opcode (alu_opcode), .alu_dina (alu_dina), .alu_dinb (alu_dinb),
      .alu_doutr (alu_doutr), .alu_doutz (alu_doutz), .alu_of (alu_of),
      .res_valid (res_valid), .res_data (res_data), .res_zero (res_zero),
      .res_of (res_of), .res_err (res_err), .res_rd (res_rd), .of_sticky (of_sticky)
   );

   // Behavioural external ALU; force_of makes it report overflow on every op
   always_comb begin
      logic ovf;
      alu_doutr = '0;
      ovf = 1'b0;
      case (alu_opcode)
         4'h0: begin
            alu_doutr = alu_dina + alu_dinb;
            ovf = (alu_dina[DW-1] == alu_dinb[DW-1]) && (alu_doutr[DW-1] != alu_dina[DW-1]);
         end
         4'h1: begin
            alu_doutr = alu_dina - alu_dinb;
            ovf = (alu_dina[DW-1] != alu_dinb[DW-1]) && (alu_doutr[DW-1] != alu_dina[DW-1]);
         end
         4'h2: alu_doutr = alu_dina & alu_dinb;
         4'h3: alu_doutr = alu_dina | alu_dinb;
         4'h4: alu_doutr = alu_dina ^ alu_dinb;
         4'h5: alu_doutr = {alu_dinb[15:0], 16'h0};
         4'h6: alu_doutr = alu_dina << alu_dinb[4:0];
         4'h7: alu_doutr = alu_dina >> alu_dinb[4:0];
         4'h8: alu_doutr = DW'($signed(alu_dina) >>> alu_dinb[4:0]);
         default: alu_doutr = '0;
      endcase
      alu_doutz = (alu_doutr == '0);
      alu_of    = ovf || force_of;
   end

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
         input logic [2:0] rs, input logic [2:0] rt, input logic isel, input logic [15:0] imm);
      return {op, rd, rs, rt, isel, 2'b00, imm};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      #1 check("cfg_blocks_ready", instr_ready, 0);
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask

   // Results captured by exec for the directed steps to compare
   logic [DW-1:0] r_data, o_a, o_b;
   logic          r_zero, r_of, r_err;
   logic [2:0]    r_rd;
   logic [3:0]    o_op;

   // Issue one instruction, check the exact N+3 latency and capture results
   task automatic exec(input string tag, input logic [31:0] ins);
      int n = 0;
      @(negedge clk);
      instr_valid = 1'b1; instr = ins;
      #1;
      while (!instr_ready && n < 20) begin @(negedge clk); #1; n++; end
      check({tag, "_accept"}, instr_ready, 1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      o_op = alu_opcode; o_a = alu_dina; o_b = alu_dinb;
      check({tag, "_lat_issue"}, res_valid, 0);
      @(negedge clk);
      check({tag, "_lat_capt"}, res_valid, 0);
      @(negedge clk);
      check({tag, "_lat_wb"}, res_valid, 1);
      r_data = res_data; r_zero = res_zero; r_of = res_of; r_err = res_err; r_rd = res_rd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy_cnt, pulses;
      logic [DW-1:0] pd0, pd1;
      logic [2:0] prd0;
      rst = 1'b1; instr_valid = 1'b0; instr = '0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_wdata = '0; force_of = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_ready", instr_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_sticky", of_sticky, 0);
      check("rst_alu_op", alu_opcode, 0);
      check("rst_alu_a", alu_dina, 0);
      check("rst_res_data", res_data, 0);
      rst = 1'b0;
      #1 check("post_rst_ready", instr_ready, 1);

      // ADD R3 = R1 + R2
      cfg_write(3'd1, 32'd5);
      cfg_write(3'd2, 32'd7);
      exec("add", mk(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0));
      check("add_alu_a", o_a, 5);
      check("add_alu_b", o_b, 7);
      check("add_data", r_data, 12);
      check("add_zero", r_zero, 0);
      check("add_err", r_err, 0);
      check("add_rd", r_rd, 3);
      exec("rd_r3", mk(4'h3, 3'd6, 3'd3, 3'd0, 1'b1, 16'h0));
      check("r3_value", r_data, 12);

      // SUB with immediate giving zero
      exec("sub", mk(4'h1, 3'd4, 3'd1, 3'd0, 1'b1, 16'd5));
      check("sub_alu_b", o_b, 5);
      check("sub_data", r_data, 0);
      check("sub_zero", r_zero, 1);
      check("sub_of", r_of, 0);
      check("sub_sticky", of_sticky, 0);

      // Immediate is zero-extended, LUI goes through ALU
      exec("lui", mk(4'h5, 3'd7, 3'd0, 3'd0, 1'b1, 16'h8001));
      check("lui_alu_b", o_b, 32'h0000_8001);
      check("lui_data", r_data, 32'h8001_0000);

      // Illegal opcode: zeroed ALU drive, error, no write
      exec("ill", mk(4'hC, 3'd2, 3'd1, 3'd2, 1'b0, 16'h0));
      check("ill_alu_op", o_op, 0);
      check("ill_alu_a", o_a, 0);
      check("ill_alu_b", o_b, 0);
      check("ill_err", r_err, 1);
      check("ill_data", r_data, 0);
      exec("rd_r2", mk(4'h3, 3'd6, 3'd2, 3'd0, 1'b1, 16'h0));
      check("r2_unchanged", r_data, 7);
      check("rd_r2_err", r_err, 0);

      // Overflow reporting only for ADD/SUB; sticky holds
      force_of = 1'b1;
      exec("add_of", mk(4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0));
      check("add_of_flag", r_of, 1);
      exec("xor_of", mk(4'h4, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0));
      check("xor_of_flag", r_of, 0);
      check("xor_data", r_data, 2);
      force_of = 1'b0;
      @(negedge clk);
      check("sticky_held", of_sticky, 1);

      // Back-to-back dependency: R3 just written with 2
      exec("dep", mk(4'h0, 3'd5, 3'd3, 3'd0, 1'b1, 16'd1));
      check("dep_data", r_data, 3);

      // Reset during CAPT aborts the instruction
      @(negedge clk);
      instr_valid = 1'b1; instr = mk(4'h0, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0);
      #1 check("abort_accept", instr_ready, 1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 check("abort_no_valid", res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("abort_ready_after", instr_ready, 1);
      check("abort_sticky_clr", of_sticky, 0);
      check("abort_alu_a_clr", alu_dina, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_quiet", res_valid, 0);
      end
      exec("rd_r5", mk(4'h0, 3'd6, 3'd5, 3'd0, 1'b1, 16'd1));
      check("r5_cleared", r_data, 1);

      // Continuous instr_valid: ready 1 cycle in 4; R0 write discarded
      cfg_write(3'd1, 32'd5);
      @(negedge clk);
      instr_valid = 1'b1;
      instr = mk(4'h0, 3'd0, 3'd1, 3'd0, 1'b1, 16'd9);
      rdy_cnt = 0; pulses = 0; pd0 = '1; pd1 = '1; prd0 = '1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (res_valid) begin
            if (pulses == 0) begin pd0 = res_data; prd0 = res_rd; end
            else pd1 = res_data;
            pulses++;
         end
         if (instr_ready) begin
            rdy_cnt++;
            @(posedge clk);
            #1 instr = mk(4'h3, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0);
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      check("b2b_ready_count", rdy_cnt, 3);
      check("b2b_pulses", pulses, 2);
      check("b2b_add_data", pd0, 14);
      check("b2b_add_rd", prd0, 0);
      check("b2b_r0_zero", pd1, 0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
